// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO feeding the register file's active-low write port,
// with a pending-write hazard check for operand fetch.
module regfile_wb_queue #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     hold,
  output logic                     wena,
  output logic [AW-1:0]            waddr,
  output logic [DW-1:0]            wdata,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !hold;

  // Payload storage; needs no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
      wena   <= 1'b1;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        occ[wr_ptr] <= 1'b1;
      end
      // A same-edge push never targets the head slot, since 0 < count < DEPTH.
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        occ[rd_ptr] <= 1'b0;
        waddr       <= mem_addr[rd_ptr];
        wdata       <= mem_data[rd_ptr];
        wena        <= 1'b0;
      end else begin
        wena        <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Hazard: any queued entry or the write currently on the port targets chk_addr.
  always_comb begin
    chk_pending = !wena && (waddr == chk_addr);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (occ[i] && (mem_addr[i] == chk_addr)) chk_pending = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue with a behavioural
// 4x32 register file attached to the write port.
module tb_regfile_wb_queue;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        wena;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  chk_addr;
  logic        chk_pending;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  logic [31:0] rf [4];
  int          n_checks;
  int          n_fail;

  regfile_wb_queue #(.DW(32), .AW(2), .DEPTH(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .wena(wena),
    .waddr(waddr), .wdata(wdata), .chk_addr(chk_addr),
    .chk_pending(chk_pending), .count(count), .empty(empty), .full(full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: captures the write on the edge where wena is low.
  always @(posedge clk) begin
    if (!wena) rf[waddr] <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    logic [31:0] exp_data [4];
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) rf[i] = 32'h0;
    clr = 1'b0; hold = 1'b0; chk_addr = 2'd0;
    drive(1'b0, 2'd0, 32'h0);

    // Reset held across edges, even with a push offered
    step();
    drive(1'b1, 2'd2, 32'h1234);
    step();
    #1;
    check("rst_wena", 32'(wena), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 2'd0, 32'h0);
    clr = 1'b1;

    // Single push, latency and hazard window
    step();
    drive(1'b1, 2'd0, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 2'd0, 32'h0);
    #1;
    check("t2_count", 32'(count), 32'h1);
    check("t2_wena_idle", 32'(wena), 32'h1);
    check("t2_pend_queued", 32'(chk_pending), 32'h1);
    step();
    check("t2_wena", 32'(wena), 32'h0);
    check("t2_waddr", 32'(waddr), 32'h0);
    check("t2_wdata", wdata, 32'hFFFF_FFFF);
    check("t2_pend_flight", 32'(chk_pending), 32'h1);
    check("t2_empty", 32'(empty), 32'h1);
    step();
    check("t2_wena_off", 32'(wena), 32'h1);
    check("t2_rf0", rf[0], 32'hFFFF_FFFF);
    check("t2_pend_done", 32'(chk_pending), 32'h0);

    // Fill under hold, overflow push ignored, then ordered drain
    hold = 1'b1;
    exp_data[0] = 32'hAAAA_AAAA; exp_data[1] = 32'hBBBB_BBBB;
    exp_data[2] = 32'hCCCC_CCCC; exp_data[3] = 32'hDDDD_DDDD;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), exp_data[i]);
      step();
    end
    check("t3_full", 32'(full), 32'h1);
    check("t3_ready", 32'(in_ready), 32'h0);
    check("t3_wena_hold", 32'(wena), 32'h1);
    drive(1'b1, 2'd0, 32'hEEEE_EEEE);
    step();
    check("t3_count_ovf", 32'(count), 32'h4);
    drive(1'b0, 2'd0, 32'h0);
    chk_addr = 2'd3;
    #1;
    check("t3_pend3", 32'(chk_pending), 32'h1);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t3_wena%0d", i), 32'(wena), 32'h0);
      check($sformatf("t3_waddr%0d", i), 32'(waddr), 32'(i));
      check($sformatf("t3_wdata%0d", i), wdata, exp_data[i]);
      check($sformatf("t3_count%0d", i), 32'(count), 32'(3 - i));
    end
    step();
    check("t3_wena_end", 32'(wena), 32'h1);
    check("t3_rf0", rf[0], 32'hAAAA_AAAA);
    check("t3_rf3", rf[3], 32'hDDDD_DDDD);

    // Simultaneous push and pop at count=2
    hold = 1'b1;
    drive(1'b1, 2'd1, 32'h100);
    step();
    drive(1'b1, 2'd2, 32'h200);
    step();
    check("t4_count2", 32'(count), 32'h2);
    hold = 1'b0;
    drive(1'b1, 2'd3, 32'h300);
    step();
    drive(1'b0, 2'd0, 32'h0);
    check("t4_count_same", 32'(count), 32'h2);
    check("t4_waddr_a", 32'(waddr), 32'h1);
    check("t4_wdata_a", wdata, 32'h100);
    step();
    check("t4_waddr_b", 32'(waddr), 32'h2);
    check("t4_count_b", 32'(count), 32'h1);
    step();
    check("t4_waddr_c", 32'(waddr), 32'h3);
    check("t4_wdata_c", wdata, 32'h300);
    check("t4_wena_c", 32'(wena), 32'h0);
    step();
    check("t4_wena_end", 32'(wena), 32'h1);

    // Two writes to the same address, last wins
    chk_addr = 2'd1;
    drive(1'b1, 2'd1, 32'h1111_1111);
    step();
    drive(1'b1, 2'd1, 32'h2222_2222);
    step();
    drive(1'b0, 2'd0, 32'h0);
    #1;
    check("t5_wdata_a", wdata, 32'h1111_1111);
    check("t5_count", 32'(count), 32'h1);
    check("t5_pend_a", 32'(chk_pending), 32'h1);
    step();
    check("t5_wdata_b", wdata, 32'h2222_2222);
    check("t5_rf1_mid", rf[1], 32'h1111_1111);
    check("t5_pend_b", 32'(chk_pending), 32'h1);
    step();
    check("t5_rf1", rf[1], 32'h2222_2222);
    check("t5_pend_done", 32'(chk_pending), 32'h0);

    // Async clear between edges discards queued entries
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 32'h5000 + 32'(i));
      step();
    end
    drive(1'b0, 2'd0, 32'h0);
    check("t6_count3", 32'(count), 32'h3);
    #2 clr = 1'b0;
    #1;
    check("t6_count", 32'(count), 32'h0);
    check("t6_empty", 32'(empty), 32'h1);
    check("t6_ready", 32'(in_ready), 32'h1);
    check("t6_wena", 32'(wena), 32'h1);
    check("t6_waddr", 32'(waddr), 32'h0);
    check("t6_wdata", wdata, 32'h0);
    #1 clr = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_no_write%0d", i), 32'(wena), 32'h1);
    end
    check("t6_rf0", rf[0], 32'hAAAA_AAAA);
    check("t6_rf1", rf[1], 32'h2222_2222);
    check("t6_rf2", rf[2], 32'h200);
    check("t6_rf3", rf[3], 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
